// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, port ids, access
// sizes and the latched transaction record.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_enum;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_enum;

  typedef enum logic [1:0] {
    DMEM_SIZE_B = 2'd0,
    DMEM_SIZE_H = 2'd1,
    DMEM_SIZE_W = 2'd2
  } op_dmem_size;

  // Everything the arbiter remembers about the transaction it granted.
  typedef struct packed {
    arb_port_enum            port;
    logic                    wr;
    op_dmem_size             size;
    logic                    zero_ex;
    logic [DATA_WIDTH-1:0]   addr;
    logic [BE_WIDTH-1:0]     be;
    logic [DATA_WIDTH-1:0]   wdata;
  } arb_txn_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals of the arbiter.
// slave : arbiter view (requests/mem response in, grants/responses/mem request out)
// master: environment view (requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  import mem_port_arbiter_pkg::*;

  // fetch port
  logic                    imem_req;
  logic [DATA_WIDTH-1:0]   imem_addr;
  logic                    imem_gnt;
  logic                    imem_rvalid;
  logic [DATA_WIDTH-1:0]   imem_rdata;
  logic                    imem_err;
  // data port
  logic                    dmem_req;
  logic                    dmem_wr;
  op_dmem_size             dmem_size;
  logic                    dmem_zero_ex;
  logic [DATA_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wr_data;
  logic                    dmem_gnt;
  logic                    dmem_rvalid;
  logic [DATA_WIDTH-1:0]   dmem_rdata;
  logic                    dmem_err;
  // memory side
  logic                    mem_req;
  logic                    mem_wr;
  logic [BE_WIDTH-1:0]     mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ready;

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  dmem_req, dmem_wr, dmem_size, dmem_zero_ex, dmem_addr, dmem_wr_data,
    output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
    output mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output dmem_req, dmem_wr, dmem_size, dmem_zero_ex, dmem_addr, dmem_wr_data,
    input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
    input  mem_req, mem_wr, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for a 32-bit word memory.
// Ports: size/zero_ex/offset/wr_data/rd_word in; be, steered wdata,
//        shifted+extended rdata and misaligned flag out.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  op_dmem_size            size,
  input  logic                   zero_ex,
  input  logic [1:0]             offset,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [DATA_WIDTH-1:0]  rd_word,
  output logic [BE_WIDTH-1:0]    be,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   misaligned
);

  logic [DATA_WIDTH-1:0] shifted;

  // Bring the addressed lane down to bit 0.
  assign shifted = rd_word >> {offset, 3'b000};

  always_comb begin
    be         = 4'hF;
    wdata      = wr_data;
    rdata      = shifted;
    misaligned = 1'b0;
    unique case (size)
      DMEM_SIZE_B: begin
        be    = 4'b0001 << offset;
        wdata = {4{wr_data[7:0]}};
        rdata = zero_ex ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      DMEM_SIZE_H: begin
        be         = 4'b0011 << offset;
        wdata      = {2{wr_data[15:0]}};
        rdata      = zero_ex ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = offset[0];
      end
      default: begin
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit memory between the
// fetch port and the load/store port.
// Ports: clk, res (sync, active-high), bus (slave view of mem_port_arbiter_if):
//   imem_* fetch handshake, dmem_* data handshake, mem_* memory handshake.
// Grants are combinational and only issued in IDLE; every other output is a flop.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 res,
  mem_port_arbiter_if.slave    bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_enum          state_q, state_nxt;
  arb_txn_t               txn_q, txn_nxt;
  arb_port_enum           rr_q, rr_nxt, sel_port;
  logic [TW-1:0]          timer_q, timer_nxt;
  logic                   mem_req_q, mem_req_nxt;
  logic                   imem_rvalid_q, imem_rvalid_nxt, imem_err_q, imem_err_nxt;
  logic                   dmem_rvalid_q, dmem_rvalid_nxt, dmem_err_q, dmem_err_nxt;
  logic [DATA_WIDTH-1:0]  imem_rdata_q, imem_rdata_nxt, dmem_rdata_q, dmem_rdata_nxt;
  logic                   imem_gnt_c, dmem_gnt_c;

  logic                   any_req, req_wr, req_zero_ex;
  op_dmem_size            req_size;
  logic [DATA_WIDTH-1:0]  req_addr;

  logic                   rsp_fire, rsp_err;
  arb_port_enum           rsp_port;
  logic [DATA_WIDTH-1:0]  rsp_data;

  logic                   al_idle;
  op_dmem_size            al_size;
  logic                   al_zero_ex;
  logic [1:0]             al_offset;
  logic [BE_WIDTH-1:0]    al_be;
  logic [DATA_WIDTH-1:0]  al_wdata, al_rdata;
  logic                   al_misaligned;

  logic                   unused_addr_hi;

  // Requester selection: a lone request wins, a collision goes to rr_q.
  assign any_req  = bus.imem_req | bus.dmem_req;
  assign sel_port = (bus.imem_req && bus.dmem_req) ? rr_q :
                    (bus.dmem_req ? ARB_PORT_D : ARB_PORT_I);

  // Request fields as seen by the selected port; fetches are word loads.
  assign req_wr      = (sel_port == ARB_PORT_D) & bus.dmem_wr;
  assign req_zero_ex = (sel_port == ARB_PORT_D) & bus.dmem_zero_ex;
  assign req_size    = (sel_port == ARB_PORT_D) ? bus.dmem_size : DMEM_SIZE_W;
  assign req_addr    = (sel_port == ARB_PORT_D) ? bus.dmem_addr : bus.imem_addr;

  // Lane logic looks at the incoming request in IDLE, the latched one afterwards.
  assign al_idle    = (state_q == ARB_IDLE);
  assign al_size    = al_idle ? req_size         : txn_q.size;
  assign al_zero_ex = al_idle ? req_zero_ex      : txn_q.zero_ex;
  assign al_offset  = al_idle ? req_addr[1:0]    : txn_q.addr[1:0];

  mem_lane_align u_align (
    .size       (al_size),
    .zero_ex    (al_zero_ex),
    .offset     (al_offset),
    .wr_data    (bus.dmem_wr_data),
    .rd_word    (bus.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .rdata      (al_rdata),
    .misaligned (al_misaligned)
  );

  // Next-state, grant and response logic.
  always_comb begin
    state_nxt       = state_q;
    txn_nxt         = txn_q;
    rr_nxt          = rr_q;
    timer_nxt       = timer_q;
    mem_req_nxt     = 1'b0;
    imem_gnt_c      = 1'b0;
    dmem_gnt_c      = 1'b0;
    rsp_fire        = 1'b0;
    rsp_err         = 1'b0;
    rsp_port        = txn_q.port;
    rsp_data        = '0;
    imem_rvalid_nxt = 1'b0;
    imem_err_nxt    = 1'b0;
    imem_rdata_nxt  = imem_rdata_q;
    dmem_rvalid_nxt = 1'b0;
    dmem_err_nxt    = 1'b0;
    dmem_rdata_nxt  = dmem_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (any_req && !res) begin
          imem_gnt_c      = (sel_port == ARB_PORT_I);
          dmem_gnt_c      = (sel_port == ARB_PORT_D);
          rr_nxt          = (sel_port == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
          txn_nxt.port    = sel_port;
          txn_nxt.wr      = req_wr;
          txn_nxt.size    = req_size;
          txn_nxt.zero_ex = req_zero_ex;
          txn_nxt.addr    = req_addr;
          txn_nxt.be      = req_wr ? al_be : 4'hF;
          txn_nxt.wdata   = req_wr ? al_wdata : '0;
          timer_nxt       = '0;
          if (al_misaligned) begin
            // Accepted but never sent to memory; answered with an error.
            state_nxt = ARB_RESP;
            rsp_fire  = 1'b1;
            rsp_err   = 1'b1;
            rsp_port  = sel_port;
          end else begin
            state_nxt   = ARB_BUSY;
            mem_req_nxt = 1'b1;
          end
        end
      end
      ARB_BUSY: begin
        if (bus.mem_ready) begin
          state_nxt = ARB_RESP;
          rsp_fire  = 1'b1;
          rsp_data  = txn_q.wr ? '0 : al_rdata;
        end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT cycles of mem_req without ready: abort.
          state_nxt = ARB_RESP;
          rsp_fire  = 1'b1;
          rsp_err   = 1'b1;
        end else begin
          mem_req_nxt = 1'b1;
          if (TIMEOUT != 0) timer_nxt = timer_q + TW'(1);
        end
      end
      ARB_RESP: begin
        state_nxt = ARB_IDLE;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase

    if (rsp_fire) begin
      if (rsp_port == ARB_PORT_I) begin
        imem_rvalid_nxt = 1'b1;
        imem_err_nxt    = rsp_err;
        imem_rdata_nxt  = rsp_data;
      end else begin
        dmem_rvalid_nxt = 1'b1;
        dmem_err_nxt    = rsp_err;
        dmem_rdata_nxt  = rsp_data;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= ARB_IDLE;
      txn_q         <= '0;
      rr_q          <= ARB_PORT_I;
      timer_q       <= '0;
      mem_req_q     <= 1'b0;
      imem_rvalid_q <= 1'b0;
      imem_err_q    <= 1'b0;
      imem_rdata_q  <= '0;
      dmem_rvalid_q <= 1'b0;
      dmem_err_q    <= 1'b0;
      dmem_rdata_q  <= '0;
    end else begin
      state_q       <= state_nxt;
      txn_q         <= txn_nxt;
      rr_q          <= rr_nxt;
      timer_q       <= timer_nxt;
      mem_req_q     <= mem_req_nxt;
      imem_rvalid_q <= imem_rvalid_nxt;
      imem_err_q    <= imem_err_nxt;
      imem_rdata_q  <= imem_rdata_nxt;
      dmem_rvalid_q <= dmem_rvalid_nxt;
      dmem_err_q    <= dmem_err_nxt;
      dmem_rdata_q  <= dmem_rdata_nxt;
    end
  end

  assign bus.imem_gnt    = imem_gnt_c;
  assign bus.dmem_gnt    = dmem_gnt_c;
  assign bus.imem_rvalid = imem_rvalid_q;
  assign bus.imem_err    = imem_err_q;
  assign bus.imem_rdata  = imem_rdata_q;
  assign bus.dmem_rvalid = dmem_rvalid_q;
  assign bus.dmem_err    = dmem_err_q;
  assign bus.dmem_rdata  = dmem_rdata_q;

  // Memory side shows the latched transaction only while requesting.
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_req_q & txn_q.wr;
  assign bus.mem_be    = mem_req_q ? txn_q.be : '0;
  assign bus.mem_addr  = mem_req_q ? {txn_q.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wdata = mem_req_q ? txn_q.wdata : '0;

  assign unused_addr_hi = ^txn_q.addr[DATA_WIDTH-1:ADDR_WIDTH];

endmodule
